// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - iterative restoring 32-bit divider, signed/unsigned, start/busy/done handshake
module div32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, dvd, dvs;
    logic             sign_q, sign_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             b_zero;

    always_comb begin
        b_zero  = (B == '0);
        a_mag   = (is_signed && A[WIDTH-1]) ? -A : A;
        b_mag   = (is_signed && B[WIDTH-1]) ? -B : B;
        shifted = {rem, dvd[WIDTH-1]};
        // rem < dvs, so the difference always fits a WIDTH+1 bit signed value
        trial   = shifted - {1'b0, dvs};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = b_zero ? DONE : RUN;
            RUN:  if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN) || (state_nxt == FIX);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_zero) begin
                            Q           <= '1;
                            R           <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd    <= a_mag;
                            dvs    <= b_mag;
                            rem    <= '0;
                            sign_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            sign_r <= is_signed & A[WIDTH-1];
                            cnt    <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    Q           <= sign_q ? -dvd : dvd;
                    R           <= sign_r ? -rem : rem;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - table-driven scoreboard bench for div32_seq
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        reset, start, is_signed;
    logic [31:0] A, B, Q, R;
    logic        busy, done, div_by_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t tbl[11];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .A(A), .B(B), .Q(Q), .R(R),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int   lat, bcnt;
        logic seen;
        vec_t e;
        sb.push_back(v);
        @(negedge clk);
        A = v.a; B = v.b; is_signed = v.s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1; bcnt = 0; seen = 1'b0;
        while (lat <= 100) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("done_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        if (seen) begin
            check("latency", lat, (v.b == 0) ? 32'd1 : 32'd34);
            check("busy_cycles", bcnt, (v.b == 0) ? 32'd0 : 32'd33);
            check("q", Q, e.q);
            check("r", R, e.r);
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
            check("q_hold", Q, e.q);
        end
    endtask

    initial begin
        int   dcount, post_busy, done_at;
        vec_t e;

        tbl[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        tbl[1]  = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        tbl[2]  = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0};
        tbl[3]  = '{32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1};
        tbl[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        tbl[5]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0};
        tbl[6]  = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0};
        tbl[7]  = '{32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678,   1'b1};
        tbl[8]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        tbl[9]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
        tbl[10] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_q", Q, 32'd0);
        check("rst_r", R, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) do_op(tbl[i]);

        // start while busy and during the done cycle must both be ignored
        sb.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0});
        @(negedge clk);
        A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0; post_busy = 0; done_at = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (dcount > 0 && busy) post_busy++;
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    done_at = i;
                    e = sb.pop_front();
                    check("ign_q", Q, e.q);
                    check("ign_r", R, e.r);
                end
                A = 32'd50; B = 32'd5; start = 1'b1;
            end
            if (i == 10) begin
                A = 32'd50; B = 32'd5; start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        check("ign_done_count", dcount, 32'd1);
        check("ign_latency", done_at, 32'd34);
        check("ign_post_busy", post_busy, 32'd0);
        check("ign_sb_empty", sb.size(), 32'd0);

        do_op('{32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0});

        // reset in the middle of a divide discards it
        @(negedge clk);
        A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_q", Q, 32'd0);
        check("mid_rst_r", R, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("mid_rst_no_activity", dcount, 32'd0);

        do_op('{32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Iterative 32-bit integer divider for the EX stage; the sequential inverse of the multiply path.
- Accepts one divide request through a start/busy/done handshake.
- Computes quotient and remainder with a one-bit-per-cycle restoring algorithm.
- The pipeline hazard unit stalls dependent instructions while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; latched with start.
- A  input  WIDTH  dividend; latched with start.
- B  input  WIDTH  divisor; latched with start.
- Q  output  WIDTH  quotient; registered.
- R  output  WIDTH  remainder; registered.
- busy  output  1  high from the edge after start is accepted until done is asserted.
- done  output  1  one-cycle pulse; Q/R/div_by_zero valid in that cycle.
- div_by_zero  output  1  registered with done; high when latched B == 0.

Behaviour:
- One clock domain. Reset is synchronous and active-high. On reset: state=IDLE, Q=0, R=0, busy=0, done=0, div_by_zero=0, counter=0.
- Reset has priority over all other events, including mid-operation. The operation in flight is discarded and no done is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at a rising edge accepts the request (edge t0).
  - If B==0: go to DONE. Set Q=all ones, R=A, div_by_zero=1.
  - Else: latch |A|, |B| (magnitudes when is_signed=1, raw values otherwise), sign_q=A[31]^B[31], sign_r=A[31] (both forced 0 when unsigned). Clear partial remainder, counter=WIDTH, go to RUN.
- RUN (one bit per edge):
  - Shift {rem, dvd} left by 1.
  - Trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem=trial, dvd[0]=1. Else dvd[0]=0.
  - Decrement counter. Go to FIX when counter reaches 0, i.e. after exactly WIDTH RUN edges.
- FIX:
  - Q = sign_q ? -dvd : dvd.
  - R = sign_r ? -rem : rem.
  - div_by_zero=0.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE at the next edge.
- Outputs: Q/R/div_by_zero hold their values until the next result is written. They are not cleared on return to IDLE.
- busy is 1 in RUN and FIX. It is 0 in IDLE and DONE.
- Latency, normal divide: accept edge t0, done high during the cycle after edge t0+WIDTH+1 (34 edges for WIDTH=32).
- Latency, divide-by-zero: done high during the cycle after edge t0.
- start while busy=1 or in DONE is ignored. No queuing, no error flag.
- Back-to-back: start asserted during the done cycle is ignored. The earliest new accept is the edge after done (IDLE).
- Signed rules: quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow case, 0x80000000 / 0xFFFFFFFF signed: Q=0x80000000, R=0. No flag; this is the natural result of magnitude arithmetic modulo 2^32.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- Divide-by-zero with is_signed=1 gives the same Q=0xFFFFFFFF, R=A.
- A==0 with B!=0: Q=0, R=0, full latency.

Test Plan:
- Unsigned: A=100, B=7, is_signed=0 -> after 34 edges done=1, Q=14, R=2, div_by_zero=0. busy high for exactly 33 cycles.
- Signed: A=0xFFFFFF9C (-100), B=7 -> Q=0xFFFFFFF2 (-14), R=0xFFFFFFFE (-2). Then A=100, B=0xFFFFFFF9 (-7) -> Q=0xFFFFFFF2, R=2.
- Divide-by-zero: A=0x12345678, B=0 -> done on the next cycle, Q=0xFFFFFFFF, R=0x12345678, div_by_zero=1, busy never high.
- Signed overflow and max unsigned: A=0x80000000, B=0xFFFFFFFF signed -> Q=0x80000000, R=0. Same operands unsigned -> Q=0, R=0x80000000.
- Start ignored while busy: start at t0 with 100/7, assert start with 50/5 at t0+10 -> one done only, Q=14, R=2. A new start after done with 50/5 -> Q=10, R=0.
- Reset mid-operation: start at t0, reset at t0+15 for one cycle -> next cycle state IDLE, Q=0, R=0, busy=0, and done never asserted for that request. A subsequent 9/4 request -> Q=2, R=1 with normal latency.
